// File: rtl/approx_mac_accum.sv
// ============================================================================
// approx_mac_accum
// ----------------------------------------------------------------------------
// Purpose:
//   Accumulates a stream of 16-bit unsigned products from the approximate
//   8x8 multiplier into a dot-product sum. Emits one result per stream, with
//   valid/ready handshakes on the input and output sides. Sits between the
//   multiplier array and the fitness / error-metric logic.
//
// Parameters:
//   ACC_W      accumulator / result width (>= 16)
//   CNT_W      term-counter width
//   MAX_TERMS  stream is force-closed after this many terms (1..2^CNT_W-1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   clr        synchronous clear: drops partial sum and any pending result
//   in_valid   product beat valid
//   in_ready   block accepts a beat (ACCUM state and no clr)
//   in_data    16-bit unsigned product
//   in_last    beat is the final term of the stream
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_acc    accumulated sum
//   out_cnt    number of terms in the sum
//   out_ovf    the sum exceeded 2^ACC_W-1 during this stream
//   out_trunc  stream force-closed at MAX_TERMS without in_last
//
// Build option:
//   MAC_SAT_EN  defined   -> on carry-out the sum clamps to 2^ACC_W-1 and
//                            stays clamped for the rest of the stream.
//               undefined -> the sum wraps modulo 2^ACC_W.
//   out_ovf flags the overflow in both builds; ports are identical.
//
// States:
//   state  | meaning
//   -------+---------------------------------------------------------------
//   ACCUM  | accepting beats, summing into acc
//   HOLD   | result registered on out_*, waiting for out_ready
// ============================================================================

module approx_mac_accum #(
    parameter int ACC_W     = 24,
    parameter int CNT_W     = 8,
    parameter int MAX_TERMS = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf,
    output logic             out_trunc
);

    generate
        if (ACC_W < 16) begin : g_bad_acc_w
            $error("approx_mac_accum: ACC_W must be >= 16");
        end
        if (MAX_TERMS < 1 || MAX_TERMS > (2**CNT_W) - 1) begin : g_bad_max_terms
            $error("approx_mac_accum: MAX_TERMS must be in 1..2^CNT_W-1");
        end
    endgenerate

    typedef enum logic {
        S_ACCUM = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic             accept;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic [ACC_W-1:0] acc_next;
    logic             ovf_next;
    logic [CNT_W-1:0] cnt_next;
    logic             hit_max;
    logic             close;

    // clr blocks acceptance so a beat presented alongside clr is never
    // folded into the freshly cleared sum.
    assign in_ready = (state == S_ACCUM) && !clr;
    assign accept   = in_valid && in_ready;

    // One extra bit on the add captures the carry-out used for overflow.
    assign sum      = {1'b0, acc} + (ACC_W+1)'(in_data);
    assign carry    = sum[ACC_W];
    assign ovf_next = ovf | carry;

`ifdef MAC_SAT_EN
    // Once clamped, ovf keeps the sum pinned at full scale even if a later
    // zero-valued beat produces no fresh carry.
    assign acc_next = ovf_next ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_next = sum[ACC_W-1:0];
`endif

    assign cnt_next = cnt + CNT_W'(1);
    assign hit_max  = (cnt_next == CNT_W'(MAX_TERMS));
    assign close    = in_last || hit_max;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_cnt   <= '0;
            out_ovf   <= 1'b0;
            out_trunc <= 1'b0;
        end else if (clr) begin
            // Result fields stay as they were; only out_valid withdraws them.
            state     <= S_ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_ACCUM: begin
                    if (accept) begin
                        acc <= acc_next;
                        cnt <= cnt_next;
                        ovf <= ovf_next;
                        if (close) begin
                            out_acc   <= acc_next;
                            out_cnt   <= cnt_next;
                            out_ovf   <= ovf_next;
                            out_trunc <= !in_last;
                            out_valid <= 1'b1;
                            state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                        state     <= S_ACCUM;
                    end
                end
                default: begin
                    state <= S_ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_approx_mac_accum.sv
// Directed bench for approx_mac_accum. Two instances: one with default
// parameters, one narrow (ACC_W=16, MAX_TERMS=3) for wrap/saturate and
// forced-close cases. sel picks which instance receives in_valid and which
// instance's outputs are observed.
module tb_approx_mac_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_ready;
    logic        sel;

    logic        a_in_ready, a_out_valid, a_out_ovf, a_out_trunc;
    logic [23:0] a_out_acc;
    logic [7:0]  a_out_cnt;
    logic        b_in_ready, b_out_valid, b_out_ovf, b_out_trunc;
    logic [15:0] b_out_acc;
    logic [7:0]  b_out_cnt;

    logic        o_in_ready, o_valid, o_ovf, o_trunc;
    logic [23:0] o_acc;
    logic [7:0]  o_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    approx_mac_accum dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid & ~sel), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_acc(a_out_acc), .out_cnt(a_out_cnt),
        .out_ovf(a_out_ovf), .out_trunc(a_out_trunc)
    );

    approx_mac_accum #(.ACC_W(16), .CNT_W(8), .MAX_TERMS(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid & sel), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_acc(b_out_acc), .out_cnt(b_out_cnt),
        .out_ovf(b_out_ovf), .out_trunc(b_out_trunc)
    );

    assign o_in_ready = sel ? b_in_ready  : a_in_ready;
    assign o_valid    = sel ? b_out_valid : a_out_valid;
    assign o_acc      = sel ? {8'h00, b_out_acc} : a_out_acc;
    assign o_cnt      = sel ? b_out_cnt   : a_out_cnt;
    assign o_ovf      = sel ? b_out_ovf   : a_out_ovf;
    assign o_trunc    = sel ? b_out_trunc : a_out_trunc;

    typedef struct {
        logic        sel;
        int          n;
        logic [15:0] d0, d1, d2, d3;
        logic        last_fin;
        logic [23:0] acc;
        logic [7:0]  cnt;
        logic        ovf;
        logic        trunc;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Presents one beat and returns #1 after the edge that accepted it.
    task automatic beat(input logic [15:0] d, input logic last);
        logic rdy;
        bit   done;
        done     = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            rdy = o_in_ready;
            @(posedge clk);
            #1;
            if (rdy === 1'b1) done = 1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: got no accept expected accept of %h", d);
        end
    endtask

    task automatic expect_result(input string tag, input logic [23:0] acc, input logic [7:0] cnt,
                                 input logic ovf, input logic trunc);
        check({tag, "_latency_valid"}, {31'b0, o_valid}, 32'd1);
        @(negedge clk);
        check({tag, "_acc"},   {8'b0, o_acc}, {8'b0, acc});
        check({tag, "_cnt"},   {24'b0, o_cnt}, {24'b0, cnt});
        check({tag, "_ovf"},   {31'b0, o_ovf}, {31'b0, ovf});
        check({tag, "_trunc"}, {31'b0, o_trunc}, {31'b0, trunc});
        check({tag, "_hold_in_ready"}, {31'b0, o_in_ready}, 32'd0);
    endtask

    task automatic set_vec(input int i, input logic s, input int n,
                           input logic [15:0] d0, input logic [15:0] d1,
                           input logic [15:0] d2, input logic [15:0] d3,
                           input logic lf, input logic [23:0] acc, input logic [7:0] cnt,
                           input logic ovf, input logic trunc);
        vecs[i].sel = s;   vecs[i].n = n;
        vecs[i].d0 = d0;   vecs[i].d1 = d1; vecs[i].d2 = d2; vecs[i].d3 = d3;
        vecs[i].last_fin = lf;
        vecs[i].acc = acc; vecs[i].cnt = cnt; vecs[i].ovf = ovf; vecs[i].trunc = trunc;
    endtask

    initial begin
        logic [15:0] dd [4];
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; out_ready = 1'b1; sel = 1'b0;

        set_vec(0, 0, 4, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 1, 24'h000A00, 8'd4, 0, 0);
        set_vec(1, 0, 1, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1, 24'h00FFFF, 8'd1, 0, 0);
        set_vec(2, 0, 3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 24'h02FFFD, 8'd3, 0, 0);
`ifdef MAC_SAT_EN
        set_vec(3, 1, 2, 16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 1, 24'h00FFFF, 8'd2, 1, 0);
        set_vec(5, 1, 3, 16'h8000, 16'h8000, 16'h0001, 16'h0000, 0, 24'h00FFFF, 8'd3, 1, 1);
`else
        set_vec(3, 1, 2, 16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 1, 24'h000001, 8'd2, 1, 0);
        set_vec(5, 1, 3, 16'h8000, 16'h8000, 16'h0001, 16'h0000, 0, 24'h000001, 8'd3, 1, 1);
`endif
        set_vec(4, 1, 3, 16'h0010, 16'h0010, 16'h0010, 16'h0000, 0, 24'h000030, 8'd3, 0, 1);
        set_vec(6, 1, 2, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 1, 24'h000003, 8'd2, 0, 0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst_out_valid", {31'b0, o_valid}, 32'd0);
            check("rst_out_acc",   {8'b0, o_acc}, 32'd0);
            check("rst_out_cnt",   {24'b0, o_cnt}, 32'd0);
            check("rst_out_flags", {30'b0, o_ovf, o_trunc}, 32'd0);
            check("rst_in_ready",  {31'b0, o_in_ready}, 32'd1);
        end
        sel = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table-driven streams
        for (int i = 0; i < 7; i++) begin
            sel = vecs[i].sel;
            out_ready = 1'b1;
            dd[0] = vecs[i].d0; dd[1] = vecs[i].d1; dd[2] = vecs[i].d2; dd[3] = vecs[i].d3;
            for (int j = 0; j < vecs[i].n; j++)
                beat(dd[j], vecs[i].last_fin && (j == vecs[i].n - 1));
            expect_result($sformatf("vec%0d", i), vecs[i].acc, vecs[i].cnt, vecs[i].ovf, vecs[i].trunc);
            @(posedge clk); #1;
            check($sformatf("vec%0d_handshake_drop", i), {31'b0, o_valid}, 32'd0);
        end

        // Backpressure: result held 5 cycles, pending beat waits, one bubble
        sel = 1'b0; out_ready = 1'b0;
        beat(16'h0010, 0);
        beat(16'h0020, 1);
        in_valid = 1'b1; in_data = 16'h0007; in_last = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid_held", {31'b0, o_valid}, 32'd1);
            check("bp_acc_held",   {8'b0, o_acc}, 32'h30);
            check("bp_cnt_held",   {24'b0, o_cnt}, 32'd2);
            check("bp_in_ready",   {31'b0, o_in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_handshake_drop", {31'b0, o_valid}, 32'd0);
        @(negedge clk);
        check("bp_bubble_ready", {31'b0, o_in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        expect_result("bp_next", 24'h7, 8'd1, 0, 0);
        @(posedge clk); #1;

        // Forced close: 4th beat waits until the result is taken
        sel = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) beat(16'h0010, 0);
        expect_result("trunc", 24'h30, 8'd3, 0, 1);
        in_valid = 1'b1; in_data = 16'h0004; in_last = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("trunc_4th_wait", {31'b0, o_in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        beat(16'h0004, 1);
        expect_result("trunc_4th", 24'h4, 8'd1, 0, 0);
        @(posedge clk); #1;

        // clr mid-stream, then clr in HOLD
        sel = 1'b0; out_ready = 1'b1;
        beat(16'h0100, 0);
        beat(16'h0200, 0);
        clr = 1'b1; in_valid = 1'b1; in_data = 16'h0055; in_last = 1'b1;
        @(negedge clk);
        check("clr_in_ready", {31'b0, o_in_ready}, 32'd0);
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        check("clr_no_result", {31'b0, o_valid}, 32'd0);
        beat(16'h0005, 1);
        expect_result("clr_after", 24'h5, 8'd1, 0, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        beat(16'h0009, 1);
        check("clr_hold_valid", {31'b0, o_valid}, 32'd1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_hold_drop", {31'b0, o_valid}, 32'd0);
        @(negedge clk);
        check("clr_hold_ready", {31'b0, o_in_ready}, 32'd1);
        out_ready = 1'b1;
        beat(16'h0011, 1);
        expect_result("clr_hold_next", 24'h11, 8'd1, 0, 0);
        @(posedge clk); #1;

        // Reset mid-stream
        beat(16'h0100, 0);
        beat(16'h0100, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mrst_valid", {31'b0, o_valid}, 32'd0);
        check("mrst_acc",   {8'b0, o_acc}, 32'd0);
        check("mrst_cnt",   {24'b0, o_cnt}, 32'd0);
        rst_n = 1'b1;
        beat(16'h0003, 1);
        expect_result("mrst_next", 24'h3, 8'd1, 0, 0);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
